pl_hazard_control: RTL and testbench

PL_HAZARD_CONTROL -- requirements
Module: pl_hazard_control

---
 rtl/pl_hazard_pkg.sv | 17 +
 rtl/pl_muldiv_timer.sv | 59 +++++
 rtl/pl_hazard_control.sv | 80 ++++++++
 tb/tb_pl_hazard_control.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pl_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// multiply/divide occupancy timer.
package pl_hazard_pkg;

    localparam int MD_CNT_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // Occupancy of N cycles is counted N-1 down to 0 while in BUSY.
    function automatic logic [MD_CNT_W-1:0] md_load(input int unsigned lat);
        return MD_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/pl_muldiv_timer.sv
// Multiply/divide occupancy timer: IDLE/BUSY FSM with a 6-bit down-counter.
// busy is high for exactly MUL_LAT or DIV_LAT cycles after a start in IDLE.
module pl_muldiv_timer
    import pl_hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [MD_CNT_W-1:0] MUL_LOAD = md_load(MUL_LAT);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD = md_load(DIV_LAT);

    md_state_t             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start while BUSY is dropped; the running operation is never restarted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == BUSY);

endmodule

// File: rtl/pl_hazard_control.sv
// Pipeline stall/flush control: load-use and mult/div (HI/LO) hazards, taken-branch flush.
// Macro PL_MULDIV_EN enables the mult/div occupancy timer and its hazard.
module pl_hazard_control
    import pl_hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_uses_rt,
    input  logic       ID_reads_hilo,
    input  logic       ID_md_op,
    input  logic [4:0] ID_EX_rt,
    input  logic       ID_EX_mem_read,
    input  logic       EX_branch_taken,
    input  logic       EX_md_start,
    input  logic       EX_md_is_div,
    output logic       pc_write,
    output logic       IF_ID_write,
    output logic       IF_ID_flush,
    output logic       ID_EX_flush,
    output logic       md_busy
);

    logic load_use;
    logic md_hazard;
    logic md_busy_w;

    // Register 0 is hard-wired zero, so a load to it never creates a dependency.
    assign load_use = ID_EX_mem_read && (ID_EX_rt != 5'd0) &&
                      ((ID_EX_rt == ID_rs) || (ID_uses_rt && (ID_EX_rt == ID_rt)));

`ifdef PL_MULDIV_EN
    pl_muldiv_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_muldiv_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (EX_md_start),
        .is_div (EX_md_is_div),
        .busy   (md_busy_w)
    );

    assign md_hazard = md_busy_w && (ID_reads_hilo || ID_md_op);
`else
    logic unused_md;

    assign md_busy_w = 1'b0;
    assign md_hazard = 1'b0;
    assign unused_md = ^{clk, ID_reads_hilo, ID_md_op, EX_md_start, EX_md_is_div};
`endif

    // Taken branch outranks any stall: the stalled ID instruction is on the wrong path.
    always_comb begin
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (load_use || md_hazard) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end
    end

    assign md_busy = md_busy_w;

endmodule

// File: tb/tb_pl_hazard_control.sv
// Self-checking bench for pl_hazard_control: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model (works with or without PL_MULDIV_EN).
module tb_pl_hazard_control;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, id_ex_rt = '0;
    logic       id_uses_rt = 0, id_reads_hilo = 0, id_md_op = 0;
    logic       id_ex_mem_read = 0, ex_branch_taken = 0;
    logic       ex_md_start = 0, ex_md_is_div = 0;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy;

    int         checks_cnt = 0;
    int         errors_cnt = 0;
    int         remaining = 0;     // cycles of mult/div occupancy still to come
    logic [4:0] obs;

    pl_hazard_control #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .ID_rs           (id_rs),
        .ID_rt           (id_rt),
        .ID_uses_rt      (id_uses_rt),
        .ID_reads_hilo   (id_reads_hilo),
        .ID_md_op        (id_md_op),
        .ID_EX_rt        (id_ex_rt),
        .ID_EX_mem_read  (id_ex_mem_read),
        .EX_branch_taken (ex_branch_taken),
        .EX_md_start     (ex_md_start),
        .EX_md_is_div    (ex_md_is_div),
        .pc_write        (pc_write),
        .IF_ID_write     (if_id_write),
        .IF_ID_flush     (if_id_flush),
        .ID_EX_flush     (id_ex_flush),
        .md_busy         (md_busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, md_busy}.
    function automatic logic [4:0] model_out();
        logic busy, lu, md;
`ifdef PL_MULDIV_EN
        busy = (remaining > 0);
`else
        busy = 1'b0;
`endif
        lu = id_ex_mem_read && (id_ex_rt != 0) &&
             ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));
        md = busy && (id_reads_hilo || id_md_op);
        if (rst)             return 5'b00110;
        if (ex_branch_taken) return {4'b1111, busy};
        if (lu || md)        return {4'b0001, busy};
        return {4'b1100, busy};
    endfunction

    task automatic model_edge();
        if (rst) remaining = 0;
`ifdef PL_MULDIV_EN
        else if (remaining > 0) remaining--;
        else if (ex_md_start) remaining = ex_md_is_div ? DIV_LAT : MUL_LAT;
`endif
    endtask

    task automatic sample();
        obs = {pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy};
    endtask

    // Called at posedge+1: settle, compare, then advance one clock.
    task automatic tick(input string tag);
        #3;
        sample();
        $display("cycle %s: in rs=%0d rt=%0d exrt=%0d ld=%0b br=%0b st=%0b dv=%0b hilo=%0b out=%05b",
                 tag, id_rs, id_rt, id_ex_rt, id_ex_mem_read, ex_branch_taken,
                 ex_md_start, ex_md_is_div, id_reads_hilo, obs);
        check_val(tag, 32'(obs), 32'(model_out()));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_ex_rt = '0;
        id_uses_rt = 0; id_reads_hilo = 0; id_md_op = 0;
        id_ex_mem_read = 0; ex_branch_taken = 0;
        ex_md_start = 0; ex_md_is_div = 0;
    endtask

    initial begin
        int busy_n;
        int exp_n;
        @(posedge clk);
        #1;
        sample();
        check_val("reset_state", 32'(obs), 32'(5'b00110));
        tick("reset_hold");
        rst = 0;

        // Load-use on rs, on rt, and the r0 exemption
        id_ex_mem_read = 1; id_ex_rt = 5'd8; id_rs = 5'd8;
        tick("lu_rs");
        sample();
        id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1;
        tick("lu_rt");
        id_uses_rt = 0;
        tick("lu_rt_unused");
        id_ex_rt = 5'd0; id_rs = 5'd0;
        tick("lu_r0");
        id_ex_rt = 5'd8; id_rs = 5'd8; ex_branch_taken = 1;
        tick("lu_branch");
        clear_inputs();

        // Multiply occupancy with HI/LO read held throughout
        ex_md_start = 1; ex_md_is_div = 0; id_reads_hilo = 1;
        tick("mul_start");
        ex_md_start = 0;
        busy_n = 0;
        for (int i = 0; i < MUL_LAT + 1; i++) begin
            tick("mul_run");
            busy_n += int'(obs[0]);
        end
`ifdef PL_MULDIV_EN
        exp_n = MUL_LAT;
`else
        exp_n = 0;
`endif
        check_val("mul_busy_cycles", 32'(busy_n), 32'(exp_n));
        check_val("mul_release_pc", 32'(obs[4]), 32'd1);
        clear_inputs();

        // Divide abandoned by an asynchronous reset at busy cycle 10
        ex_md_start = 1; ex_md_is_div = 1;
        tick("div_start");
        clear_inputs();
        id_md_op = 1;
        for (int i = 0; i < 9; i++) tick("div_run");
        #1;
        rst = 1;
        #1;
        sample();
        check_val("async_rst", 32'(obs), 32'(5'b00110));
        #1;
        remaining = 0;
        @(posedge clk);
        model_edge();
        #1;
        tick("rst_hold");
        rst = 0;
        tick("after_rst");
        tick("after_rst2");
        clear_inputs();

        // Divide with a taken branch at busy cycle 5 and ignored restarts
        ex_md_start = 1; ex_md_is_div = 1;
        tick("div2_start");
        ex_md_is_div = 0;
        busy_n = 0;
        for (int i = 0; i < DIV_LAT + 4; i++) begin
            ex_branch_taken = (i == 4);
            ex_md_start = (i == 10);
            id_reads_hilo = 1;
            tick("div2_run");
            busy_n += int'(obs[0]);
            if (i == DIV_LAT - 1) ex_md_start = 0;
        end
`ifdef PL_MULDIV_EN
        exp_n = DIV_LAT;
`else
        exp_n = 0;
`endif
        check_val("div_busy_cycles", 32'(busy_n), 32'(exp_n));
        clear_inputs();

`ifndef PL_MULDIV_EN
        ex_md_start = 1; id_reads_hilo = 1;
        tick("nomd_start");
        #3;
        check_val("nomd_busy", 32'(md_busy), 32'd0);
        check_val("nomd_pc", 32'(pc_write), 32'd1);
        @(posedge clk);
        model_edge();
        #1;
        clear_inputs();
`endif

        // Randomized traffic with occasional asynchronous reset pulses
        for (int i = 0; i < 600; i++) begin
            id_rs           = 5'($urandom_range(3, 0));
            id_rt           = 5'($urandom_range(3, 0));
            id_ex_rt        = 5'($urandom_range(3, 0));
            id_uses_rt      = 1'($urandom_range(1, 0));
            id_ex_mem_read  = 1'($urandom_range(1, 0));
            ex_branch_taken = ($urandom_range(7, 0) == 0);
            ex_md_start     = ($urandom_range(5, 0) == 0);
            ex_md_is_div    = ($urandom_range(3, 0) == 0);
            id_reads_hilo   = ($urandom_range(2, 0) == 0);
            id_md_op        = ($urandom_range(3, 0) == 0);
            rst             = ($urandom_range(99, 0) == 0);
            if (rst) remaining = 0;
            tick("rand");
            rst = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
